// File: rtl/mul_pkg.sv
// Shared types and defaults for the radix-4 Booth multiplier.
package mul_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    ZERO,
    POS1,
    POS2,
    NEG1,
    NEG2
  } booth_digit_e;

endpackage

// File: rtl/booth_mul_encoder.sv
// Radix-4 Booth recoder: maps the bit triple {q[2i+1], q[2i], q[2i-1]} to a digit.
module booth_encoder
  import mul_pkg::*;
(
  input  logic [2:0]   triple,
  output booth_digit_e digit_c
);

  // Pure lookup of the Booth digit for the current triple.
  always_comb begin
    digit_c = ZERO;
    unique case (triple)
      3'b001, 3'b010: digit_c = POS1;
      3'b011:         digit_c = POS2;
      3'b100:         digit_c = NEG2;
      3'b101, 3'b110: digit_c = NEG1;
      default:        digit_c = ZERO;
    endcase
  end

endmodule

// File: rtl/booth_mul.sv
// Sequential signed WIDTHxWIDTH multiplier, radix-4 Booth, two multiplier bits per cycle.
module booth_mul
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] M,
  input  logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_lo,
  output logic [WIDTH-1:0] product_hi
);

  // Two guard bits let +/-2M of the most negative multiplicand fit.
  localparam int unsigned AW    = WIDTH + 2;
  localparam int unsigned QW    = WIDTH + 1;
  localparam int unsigned STEPS = WIDTH / 2;
  localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  state_e           state;
  state_e           state_next;
  logic [CW-1:0]    count;
  logic [AW-1:0]    acc;
  logic [AW-1:0]    mcand;
  logic [QW-1:0]    mplier;

  booth_digit_e     digit_c;
  logic [AW-1:0]    addend_c;
  logic [AW-1:0]    sum_c;
  logic [AW+QW-1:0] shifted_c;
  logic             last_step_c;

  booth_encoder u_enc (
    .triple  (mplier[2:0]),
    .digit_c (digit_c)
  );

  // Select the partial product for this step in AW-bit two's complement.
  always_comb begin
    addend_c = '0;
    unique case (digit_c)
      POS1:    addend_c = mcand;
      POS2:    addend_c = {mcand[AW-2:0], 1'b0};
      NEG1:    addend_c = AW'(-mcand);
      NEG2:    addend_c = AW'(-{mcand[AW-2:0], 1'b0});
      default: addend_c = '0;
    endcase
  end

  // Add then arithmetic-shift {acc, multiplier} right by two.
  always_comb begin
    sum_c       = acc + addend_c;
    shifted_c   = $signed({sum_c, mplier}) >>> 2;
    last_step_c = (count == CW'(STEPS - 1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (last_step_c) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath, counter and registered status outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      count      <= '0;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      product_lo <= '0;
      product_hi <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      done <= (state_next == DONE);
      unique case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {{2{M[WIDTH-1]}}, M};
            mplier <= {Q, 1'b0};
            acc    <= '0;
            count  <= '0;
          end
        end
        CALC: begin
          acc    <= shifted_c[AW+QW-1:QW];
          mplier <= shifted_c[QW-1:0];
          count  <= count + CW'(1);
          // Product sits one bit above the bottom; bit 0 is the spent top bit of Q.
          if (last_step_c) begin
            product_hi <= shifted_c[QW+WIDTH-1:QW];
            product_lo <= shifted_c[WIDTH:1];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul.sv
// Self-checking bench for booth_mul: arithmetic reference model plus directed vectors.
module tb_booth_mul;

  logic        clk;
  logic        resetn;
  logic        start;
  logic [31:0] M;
  logic [31:0] Q;
  logic        busy;
  logic        done;
  logic [31:0] product_lo;
  logic [31:0] product_hi;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 0;

  booth_mul #(.WIDTH(32)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .M          (M),
    .Q          (Q),
    .busy       (busy),
    .done       (done),
    .product_lo (product_lo),
    .product_hi (product_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: signed product, 17 busy cycles, done on the last, result held.
  logic [63:0] pend, exp_prod;
  bit          exp_busy, exp_done;
  int          remain;

  always @(posedge clk) begin
    if (!resetn) begin
      remain   <= 0;
      exp_busy <= 1'b0;
      exp_done <= 1'b0;
      exp_prod <= '0;
    end else if (remain == 0) begin
      exp_done <= 1'b0;
      if (start) begin
        pend     <= 64'(longint'($signed(M)) * longint'($signed(Q)));
        remain   <= 17;
        exp_busy <= 1'b1;
      end else begin
        exp_busy <= 1'b0;
      end
    end else begin
      remain   <= remain - 1;
      exp_done <= (remain == 2);
      if (remain == 2) exp_prod <= pend;
      if (remain == 1) exp_busy <= 1'b0;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_busy", 64'(busy), 64'(exp_busy));
      chk("m_done", 64'(done), 64'(exp_done));
      chk("m_prod", {product_hi, product_lo}, exp_prod);
    end
  end

  // Issue one multiply; optionally inject a start at a given cycle and at the done cycle.
  task automatic run_mul(input logic [31:0] m, input logic [31:0] q,
                         input logic [31:0] e_hi, input logic [31:0] e_lo,
                         input int inject_at, input bit inject_done, input string tag);
    int n;
    @(negedge clk);
    start = 1'b1; M = m; Q = q;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      if (n == inject_at) begin
        start = 1'b1; M = 32'd2; Q = 32'd2;
      end else begin
        start = 1'b0;
      end
    end
    chk({tag, "_latency"}, 64'(n), 64'd16);
    chk({tag, "_hi"}, 64'(product_hi), 64'(e_hi));
    chk({tag, "_lo"}, 64'(product_lo), 64'(e_lo));
    if (inject_done) begin
      start = 1'b1; M = 32'd3; Q = 32'd3;
    end
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_after"}, 64'(busy), 64'd0);
    chk({tag, "_done_after"}, 64'(done), 64'd0);
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; M = '0; Q = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp_en = 1'b1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_prod", {product_hi, product_lo}, 64'd0);
    resetn = 1'b1;

    run_mul(32'd6, 32'd7, 32'h0, 32'h2A, -1, 0, "t1");
    run_mul(32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, -1, 0, "t2");
    run_mul(32'h80000000, 32'h80000000, 32'h40000000, 32'h0, -1, 0, "t3a");
    run_mul(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h1, -1, 0, "t3b");
    run_mul(32'd100, 32'd25, 32'h0, 32'd2500, 5, 1, "t4");
    repeat (3) @(negedge clk);
    chk("t4_ignored", 64'(busy), 64'd0);

    // Reset in the middle of a multiply.
    @(negedge clk);
    start = 1'b1; M = 32'd38; Q = 32'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_prod", {product_hi, product_lo}, 64'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t5_no_done", 64'(done), 64'd0);
    end
    run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, -1, 0, "t5b");

    // Result holds while idle with changing operands.
    run_mul(32'd9, 32'd9, 32'h0, 32'd81, -1, 0, "t6");
    for (int i = 0; i < 10; i++) begin
      M = ~M; Q = Q + 32'd13;
      @(negedge clk);
      chk("t6_hold_lo", 64'(product_lo), 64'd81);
      chk("t6_hold_done", 64'(done), 64'd0);
    end

    // Model self-pin on a signed corner.
    run_mul(32'h80000000, 32'd1, 32'hFFFFFFFF, 32'h80000000, -1, 0, "t7");

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
